vga_frame_writer: RTL and testbench

- Write side of the 640x480 pixel-index frame memory; the VGA display path reads that memory by linear address (y*640 + x).
- When game logic locks a falling tetromino, this block paints the piece's four square blocks into memory with the piece's color index.
- It also clears the playfield rectangle to background on game start or after a line clear.
- Output is one pixel write per clock on a simple write port (address, index, enable) for the dual-port index RAM.

---
 rtl/vga_frame_writer.sv | 167 ++++++++++++++++
 tb/tb_vga_frame_writer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_writer.sv
// vga_frame_writer: write-side sequencer for the 640x480 pixel-index frame memory.
// Paints the four blocks of a locked tetromino or clears the playfield, one pixel per clock.
module vga_frame_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BLOCK_SIZE = 20,
  parameter int FIELD_X0   = 100,
  parameter int FIELD_Y0   = 40,
  parameter int FIELD_W    = 200,
  parameter int FIELD_H    = 400,
  parameter int BG_INDEX   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        paint_req,
  input  logic        clear_req,
  input  logic [9:0]  b1x,
  input  logic [9:0]  b1y,
  input  logic [9:0]  b2x,
  input  logic [9:0]  b2y,
  input  logic [9:0]  b3x,
  input  logic [9:0]  b3y,
  input  logic [9:0]  b4x,
  input  logic [9:0]  b4y,
  input  logic [7:0]  blockType,
  output logic [18:0] wrAddr,
  output logic [7:0]  wrIndex,
  output logic        wrEn,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for clear_req / paint_req (clear has priority)
  // PAINT | sweeping blk/dy/dx over the four latched blocks
  // CLEAR | sweeping the playfield rectangle with BG_INDEX
  // DONE  | one-cycle completion pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, PAINT, CLEAR, DONE} stateType;

  stateType    state, stateNext;
  logic [1:0]  blk, blkNext;
  logic [7:0]  xCnt, xCntNext;
  logic [8:0]  yCnt, yCntNext;
  logic [9:0]  bxLat [4];
  logic [9:0]  byLat [4];
  logic [7:0]  typeLat;
  logic [18:0] wrAddrNext;
  logic [7:0]  wrIndexNext;
  logic        wrEnNext, busyNext, doneNext;
  logic [10:0] px, py;
  logic [18:0] pyWide, pixAddr;
  logic        accept;

  assign accept = (state == IDLE) && (clear_req || paint_req);

  // 11-bit pixel coordinates so block origins near 1023 cannot wrap into range
  always_comb begin
    if (state == CLEAR) begin
      px = 11'(FIELD_X0) + {3'b0, xCnt};
      py = 11'(FIELD_Y0) + {2'b0, yCnt};
    end else begin
      px = {1'b0, bxLat[blk]} + {3'b0, xCnt};
      py = {1'b0, byLat[blk]} + {2'b0, yCnt};
    end
    pyWide = {8'b0, py};
    if (H_RES == 640) pixAddr = (pyWide << 9) + (pyWide << 7) + {8'b0, px};
    else              pixAddr = pyWide * 19'(H_RES) + {8'b0, px};
  end

  always_comb begin
    stateNext   = state;
    blkNext     = blk;
    xCntNext    = xCnt;
    yCntNext    = yCnt;
    wrAddrNext  = wrAddr;
    wrIndexNext = wrIndex;
    wrEnNext    = 1'b0;
    busyNext    = 1'b0;
    doneNext    = 1'b0;
    case (state)
      IDLE: begin
        blkNext  = '0;
        xCntNext = '0;
        yCntNext = '0;
        if (clear_req)      stateNext = CLEAR;
        else if (paint_req) stateNext = PAINT;
      end
      PAINT: begin
        wrAddrNext  = pixAddr;
        wrIndexNext = typeLat;
        wrEnNext    = (px < 11'(H_RES)) && (py < 11'(V_RES));
        busyNext    = 1'b1;
        if (xCnt == 8'(BLOCK_SIZE - 1)) begin
          xCntNext = '0;
          if (yCnt == 9'(BLOCK_SIZE - 1)) begin
            yCntNext = '0;
            blkNext  = blk + 2'd1;
            if (blk == 2'd3) stateNext = DONE;
          end else begin
            yCntNext = yCnt + 9'd1;
          end
        end else begin
          xCntNext = xCnt + 8'd1;
        end
      end
      CLEAR: begin
        wrAddrNext  = pixAddr;
        wrIndexNext = 8'(BG_INDEX);
        wrEnNext    = 1'b1;
        busyNext    = 1'b1;
        if (xCnt == 8'(FIELD_W - 1)) begin
          xCntNext = '0;
          if (yCnt == 9'(FIELD_H - 1)) begin
            yCntNext  = '0;
            stateNext = DONE;
          end else begin
            yCntNext = yCnt + 9'd1;
          end
        end else begin
          xCntNext = xCnt + 8'd1;
        end
      end
      DONE: begin
        doneNext  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      blk     <= '0;
      xCnt    <= '0;
      yCnt    <= '0;
      typeLat <= '0;
      for (int i = 0; i < 4; i++) begin
        bxLat[i] <= '0;
        byLat[i] <= '0;
      end
      wrAddr  <= '0;
      wrIndex <= '0;
      wrEn    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= stateNext;
      blk     <= blkNext;
      xCnt    <= xCntNext;
      yCnt    <= yCntNext;
      wrAddr  <= wrAddrNext;
      wrIndex <= wrIndexNext;
      wrEn    <= wrEnNext;
      busy    <= busyNext;
      done    <= doneNext;
      if (accept) begin
        bxLat[0] <= b1x;  byLat[0] <= b1y;
        bxLat[1] <= b2x;  byLat[1] <= b2y;
        bxLat[2] <= b3x;  byLat[2] <= b3y;
        bxLat[3] <= b4x;  byLat[3] <= b4y;
        typeLat  <= blockType;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_writer.sv
// tb_vga_frame_writer: directed checks of paint, clip, clear, request arbitration and reset abort.
// Expected addresses and counts are hand-computed from y*640 + x.
module tb_vga_frame_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        paint_req, clear_req;
  logic [9:0]  b1x, b1y, b2x, b2y, b3x, b3y, b4x, b4y;
  logic [7:0]  blockType;
  logic [18:0] wrAddr;
  logic [7:0]  wrIndex;
  logic        wrEn, busy, done;

  int compared   = 0;
  int mismatched = 0;

  int busyCyc, wrCyc, badIdx, doneCnt, gapErr, firstBusy, lastBusy, doneCyc, finished;
  int injectAt;
  logic [18:0] addrLog [$];

  vga_frame_writer dut (
    .clock(clock), .reset(reset), .paint_req(paint_req), .clear_req(clear_req),
    .b1x(b1x), .b1y(b1y), .b2x(b2x), .b2y(b2y),
    .b3x(b3x), .b3y(b3y), .b4x(b4x), .b4y(b4y),
    .blockType(blockType), .wrAddr(wrAddr), .wrIndex(wrIndex),
    .wrEn(wrEn), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    if (obs != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setBlocks(input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3, input int x4, input int y4,
                           input int t);
    b1x = 10'(x1); b1y = 10'(y1); b2x = 10'(x2); b2y = 10'(y2);
    b3x = 10'(x3); b3y = 10'(y3); b4x = 10'(x4); b4y = 10'(y4);
    blockType = 8'(t);
  endtask

  // Pulses the request across one rising edge; returns at the negedge after acceptance.
  task automatic startReq(input logic p, input logic c);
    paint_req = p;
    clear_req = c;
    @(negedge clock);
    paint_req = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic runOp(input int expIdx, input int maxCyc);
    logic prevBusy;
    busyCyc = 0; wrCyc = 0; badIdx = 0; doneCnt = 0; gapErr = 0;
    firstBusy = -1; lastBusy = -1; doneCyc = -1; finished = 0;
    addrLog.delete();
    check("busy_before_first_write", int'(busy), 0);
    prevBusy = 1'b0;
    for (int cyc = 0; cyc < maxCyc && finished == 0; cyc++) begin
      @(negedge clock);
      paint_req = 1'b0;
      if (busy) begin
        if (firstBusy < 0) firstBusy = cyc;
        if (busyCyc > 0 && !prevBusy) gapErr++;
        if (doneCnt > 0) gapErr++;
        addrLog.push_back(wrAddr);
        if (wrEn) begin
          wrCyc++;
          if (int'(wrIndex) != expIdx) badIdx++;
        end
        if (busyCyc == injectAt) begin
          setBlocks(0, 0, 0, 0, 0, 0, 0, 0, 1);
          paint_req = 1'b1;
        end
        busyCyc++;
        lastBusy = cyc;
      end else begin
        if (wrEn) gapErr++;
        if (done) begin
          doneCnt++;
          doneCyc = cyc;
        end else if (doneCnt > 0) begin
          finished = 1;
        end
      end
      prevBusy = busy;
    end
    check("op_terminated", finished, 1);
    check("first_write_latency", firstBusy, 0);
    check("done_count", doneCnt, 1);
    check("done_after_last_write", doneCyc, lastBusy + 1);
    check("contiguity_errors", gapErr, 0);
    check("wrong_index_writes", badIdx, 0);
  endtask

  task automatic watchIdle(input string tag, input int n);
    int active = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (wrEn || busy) active++;
    end
    check(tag, active, 0);
  endtask

  initial begin
    reset = 1'b1;
    paint_req = 1'b0;
    clear_req = 1'b0;
    injectAt = -1;
    setBlocks(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    check("reset_wrEn", int'(wrEn), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_wrAddr", int'(wrAddr), 0);
    check("reset_wrIndex", int'(wrIndex), 0);
    reset = 1'b0;
    watchIdle("idle_after_reset", 5);

    // Row of four blocks along the top edge
    setBlocks(0, 0, 20, 0, 40, 0, 60, 0, 3);
    startReq(1'b1, 1'b0);
    runOp(3, 2000);
    check("paint_busy_cycles", busyCyc, 1600);
    check("paint_writes", wrCyc, 1600);
    check("paint_addr_w1", int'(addrLog[0]), 0);
    check("paint_addr_w20", int'(addrLog[19]), 19);
    check("paint_addr_w21", int'(addrLog[20]), 640);
    check("paint_addr_w400", int'(addrLog[399]), 12179);
    check("paint_addr_w401", int'(addrLog[400]), 20);
    check("paint_addr_w1600", int'(addrLog[1599]), 12239);

    // Block 1 hangs off the bottom-right corner; only its 10x10 corner is visible
    setBlocks(630, 470, 100, 100, 200, 200, 300, 300, 4);
    startReq(1'b1, 1'b0);
    runOp(4, 2000);
    check("clip_busy_cycles", busyCyc, 1600);
    check("clip_writes", wrCyc, 1300);
    check("clip_addr_w1", int'(addrLog[0]), 301430);
    check("clip_addr_w401", int'(addrLog[400]), 64100);

    // Request and input changes mid-paint must not disturb the latched operation
    setBlocks(100, 200, 120, 200, 140, 200, 160, 200, 9);
    injectAt = 499;
    startReq(1'b1, 1'b0);
    runOp(9, 2000);
    injectAt = -1;
    check("inject_busy_cycles", busyCyc, 1600);
    check("inject_writes", wrCyc, 1600);
    check("inject_addr_w601", int'(addrLog[600]), 134520);
    check("inject_addr_w1600", int'(addrLog[1599]), 140339);
    watchIdle("inject_no_followup", 20);

    // Simultaneous requests: clear wins, paint is dropped
    setBlocks(0, 0, 20, 0, 40, 0, 60, 0, 7);
    startReq(1'b1, 1'b1);
    runOp(0, 81000);
    check("clear_busy_cycles", busyCyc, 80000);
    check("clear_writes", wrCyc, 80000);
    check("clear_addr_first", int'(addrLog[0]), 25700);
    check("clear_addr_w201", int'(addrLog[200]), 26340);
    check("clear_addr_last", int'(addrLog[79999]), 281259);
    watchIdle("clear_no_paint_follows", 20);

    // Reset mid-clear aborts asynchronously
    setBlocks(0, 0, 0, 0, 0, 0, 0, 0, 5);
    startReq(1'b0, 1'b1);
    repeat (100) @(negedge clock);
    check("abort_busy_before_reset", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("abort_wrEn", int'(wrEn), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_wrAddr", int'(wrAddr), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    watchIdle("abort_no_resume", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
